// File: rtl/alu_issue_stage_if.sv
// Handshake and data bundle between decode, the issue stage and the ALU.
//   master: environment side (decode drives the instruction, ALU drives status
//           and out_ready).
//   slave : the issue stage itself.
// Signals: flush, in_valid/in_ready, opcode, rn_data, rm_data, imm,
//          out_valid/out_ready, alu_fs, alu_a, alu_b, set_flags, illegal,
//          alu_status, flags.
interface alu_issue_stage_if #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned IMM_W = 12
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [10:0]      opcode;
  logic [WIDTH-1:0] rn_data;
  logic [WIDTH-1:0] rm_data;
  logic [IMM_W-1:0] imm;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       alu_fs;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             set_flags;
  logic             illegal;
  logic [3:0]       alu_status;
  logic [3:0]       flags;

  modport master (
    output flush, in_valid, opcode, rn_data, rm_data, imm, out_ready, alu_status,
    input  in_ready, out_valid, alu_fs, alu_a, alu_b, set_flags, illegal, flags
  );

  modport slave (
    input  flush, in_valid, opcode, rn_data, rm_data, imm, out_ready, alu_status,
    output in_ready, out_valid, alu_fs, alu_a, alu_b, set_flags, illegal, flags
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Decode/issue stage in front of the 64-bit LEGv8 ALU.
// Decodes the opcode into an ALU function select, builds operands A/B (with
// immediate zero/sign extension), registers them behind a valid/ready
// handshake, and owns the architectural NZCV flag register.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - alu_issue_stage_if slave modport (decode in, ALU out, flags)
module alu_issue_stage #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned IMM_W = 12
) (
  input logic              clk,
  input logic              rst_n,
  alu_issue_stage_if.slave bus
);

  localparam logic [3:0] FsAnd  = 4'b0000;
  localparam logic [3:0] FsOrr  = 4'b0001;
  localparam logic [3:0] FsAdd  = 4'b0010;
  localparam logic [3:0] FsSub  = 4'b0110;
  localparam logic [3:0] FsPass = 4'b0111;

  // Immediate forms: I-type imm12 is zero-extended, D-type offset imm[8:0] is
  // sign-extended. Upper imm bits are ignored for D-type.
  logic [WIDTH-1:0] imm_zext;
  logic [WIDTH-1:0] imm_sext;
  assign imm_zext = {{(WIDTH-12){1'b0}}, bus.imm[11:0]};
  assign imm_sext = {{(WIDTH-9){bus.imm[8]}}, bus.imm[8:0]};

  logic [3:0]       dec_fs;
  logic [WIDTH-1:0] dec_a;
  logic [WIDTH-1:0] dec_b;
  logic             dec_sf;
  logic             dec_ill;

  always_comb begin
    dec_fs  = FsAnd;
    dec_a   = bus.rn_data;
    dec_b   = bus.rm_data;
    dec_sf  = 1'b0;
    dec_ill = 1'b0;
    casez (bus.opcode)
      11'b10001011000: dec_fs = FsAdd;                                  // ADD
      11'b10101011000: begin dec_fs = FsAdd; dec_sf = 1'b1; end         // ADDS
      11'b11001011000: dec_fs = FsSub;                                  // SUB
      11'b11101011000: begin dec_fs = FsSub; dec_sf = 1'b1; end         // SUBS
      11'b10001010000: dec_fs = FsAnd;                                  // AND
      11'b10101010000: dec_fs = FsOrr;                                  // ORR
      11'b1001000100?: begin dec_fs = FsAdd; dec_b = imm_zext; end      // ADDI
      11'b1011000100?: begin                                            // ADDIS
        dec_fs = FsAdd;
        dec_b  = imm_zext;
        dec_sf = 1'b1;
      end
      11'b1101000100?: begin dec_fs = FsSub; dec_b = imm_zext; end      // SUBI
      11'b1111000100?: begin                                            // SUBIS
        dec_fs = FsSub;
        dec_b  = imm_zext;
        dec_sf = 1'b1;
      end
      11'b1001001000?: begin dec_fs = FsAnd; dec_b = imm_zext; end      // ANDI
      11'b1011001000?: begin dec_fs = FsOrr; dec_b = imm_zext; end      // ORRI
      11'b11111000010,                                                  // LDUR
      11'b11111000000: begin dec_fs = FsAdd; dec_b = imm_sext; end      // STUR
      11'b10110100???: dec_fs = FsPass;                                 // CBZ
      default: begin
        // Unknown ops still flow downstream, tagged illegal with zeroed operands.
        dec_a   = '0;
        dec_b   = '0;
        dec_ill = 1'b1;
      end
    endcase
  end

  logic             valid_q, valid_d;
  logic [3:0]       fs_q, fs_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sf_q, sf_d;
  logic             ill_q, ill_d;
  logic [3:0]       flags_q, flags_d;

  logic accept;
  logic xfer;

  assign bus.in_ready = !bus.flush && (!valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign xfer         = valid_q && bus.out_ready;

  always_comb begin
    valid_d = valid_q;
    fs_d    = fs_q;
    a_d     = a_q;
    b_d     = b_q;
    sf_d    = sf_q;
    ill_d   = ill_q;
    flags_d = flags_q;
    if (bus.flush) begin
      // Flush wins over both transfers: kill the op, leave flags untouched.
      valid_d = 1'b0;
    end else begin
      if (xfer) begin
        valid_d = 1'b0;
        if (sf_q) flags_d = bus.alu_status;
      end
      if (accept) begin
        valid_d = 1'b1;
        fs_d    = dec_fs;
        a_d     = dec_a;
        b_d     = dec_b;
        sf_d    = dec_sf;
        ill_d   = dec_ill;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      fs_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sf_q    <= 1'b0;
      ill_q   <= 1'b0;
      flags_q <= '0;
    end else begin
      valid_q <= valid_d;
      fs_q    <= fs_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sf_q    <= sf_d;
      ill_q   <= ill_d;
      flags_q <= flags_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.alu_fs    = fs_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.set_flags = sf_q;
  assign bus.illegal   = ill_q;
  assign bus.flags     = flags_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  logic clk;
  logic rst_n;

  alu_issue_stage_if #(.WIDTH(64), .IMM_W(12)) bus ();

  alu_issue_stage #(.WIDTH(64), .IMM_W(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] opc;
    logic [63:0] rn;
    logic [63:0] rm;
    logic [11:0] imm;
    logic [3:0]  fs;
    logic [63:0] b;
    logic        sf;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [3:0]  fs;
    logic [63:0] a;
    logic [63:0] b;
    logic        sf;
    logic        ill;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];
  exp_t drv_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input vec_t v);
    bus.opcode   = v.opc;
    bus.rn_data  = v.rn;
    bus.rm_data  = v.rm;
    bus.imm      = v.imm;
    bus.in_valid = 1'b1;
    drv_exp.fs   = v.fs;
    drv_exp.a    = v.ill ? 64'd0 : v.rn;
    drv_exp.b    = v.b;
    drv_exp.sf   = v.sf;
    drv_exp.ill  = v.ill;
  endtask

  // Scoreboard: push on accept, pop on transfer out; a flushed op is discarded.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (bus.out_valid && (bus.out_ready || bus.flush)) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          if (!bus.flush) begin
            check("sb_fs",  {60'd0, bus.alu_fs}, {60'd0, e.fs});
            check("sb_a",   bus.alu_a, e.a);
            check("sb_b",   bus.alu_b, e.b);
            check("sb_sf",  {63'd0, bus.set_flags}, {63'd0, e.sf});
            check("sb_ill", {63'd0, bus.illegal}, {63'd0, e.ill});
          end
        end
      end
      if (bus.in_valid && bus.in_ready) sb_q.push_back(drv_exp);
    end
  end

  vec_t vecs[$];

  function automatic vec_t mk(input logic [10:0] opc, input logic [63:0] rn,
                              input logic [63:0] rm, input logic [11:0] imm,
                              input logic [3:0] fs, input logic [63:0] b,
                              input logic sf, input logic ill);
    vec_t v;
    v.opc = opc; v.rn = rn; v.rm = rm; v.imm = imm;
    v.fs = fs; v.b = b; v.sf = sf; v.ill = ill;
    return v;
  endfunction

  initial begin
    vecs.push_back(mk(11'b10001011000, 64'd5, 64'd7, 12'h000, 4'b0010, 64'd7, 1'b0, 1'b0));
    vecs.push_back(mk(11'b10101011000, 64'h8000_0000_0000_0000, 64'd1, 12'h055, 4'b0010,
                      64'd1, 1'b1, 1'b0));
    vecs.push_back(mk(11'b11001011000, 64'd20, 64'd3, 12'h000, 4'b0110, 64'd3, 1'b0, 1'b0));
    vecs.push_back(mk(11'b11101011000, 64'd1, 64'd2, 12'h000, 4'b0110, 64'd2, 1'b1, 1'b0));
    vecs.push_back(mk(11'b10001010000, 64'hF0F0, 64'h0FF0, 12'h000, 4'b0000, 64'h0FF0,
                      1'b0, 1'b0));
    vecs.push_back(mk(11'b10101010000, 64'hA5, 64'h5A, 12'h000, 4'b0001, 64'h5A, 1'b0, 1'b0));
    vecs.push_back(mk(11'b10010001000, 64'd10, 64'd999, 12'h123, 4'b0010, 64'h123, 1'b0, 1'b0));
    vecs.push_back(mk(11'b10110001001, 64'd11, 64'd999, 12'h800, 4'b0010, 64'h800, 1'b1, 1'b0));
    vecs.push_back(mk(11'b11010001001, 64'd12, 64'd999, 12'h007, 4'b0110, 64'h7, 1'b0, 1'b0));
    vecs.push_back(mk(11'b11110001000, 64'd13, 64'd999, 12'hABC, 4'b0110, 64'hABC, 1'b1, 1'b0));
    vecs.push_back(mk(11'b10010010000, 64'd14, 64'd999, 12'hFFF, 4'b0000,
                      64'h0000_0000_0000_0FFF, 1'b0, 1'b0));
    vecs.push_back(mk(11'b10110010001, 64'd15, 64'd999, 12'h001, 4'b0001, 64'h1, 1'b0, 1'b0));
    vecs.push_back(mk(11'b11111000010, 64'h1000, 64'd999, 12'h1F8, 4'b0010,
                      64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0));
    vecs.push_back(mk(11'b11111000010, 64'h2000, 64'd999, 12'hE0F, 4'b0010, 64'hF, 1'b0, 1'b0));
    vecs.push_back(mk(11'b11111000000, 64'h3000, 64'd999, 12'h0FF, 4'b0010, 64'hFF, 1'b0, 1'b0));
    vecs.push_back(mk(11'b10110100101, 64'd16, 64'hDEAD, 12'h000, 4'b0111, 64'hDEAD, 1'b0, 1'b0));
    vecs.push_back(mk(11'b11111111111, 64'd5, 64'd6, 12'h123, 4'b0000, 64'd0, 1'b0, 1'b1));
    vecs.push_back(mk(11'b00000000000, 64'd5, 64'd6, 12'h000, 4'b0000, 64'd0, 1'b0, 1'b1));
    vecs.push_back(mk(11'b10001011001, 64'd5, 64'd6, 12'h000, 4'b0000, 64'd0, 1'b0, 1'b1));

    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.opcode = '0; bus.rn_data = '0;
    bus.rm_data = '0; bus.imm = '0; bus.out_ready = 1'b1; bus.alu_status = '0;
    drv_exp = '{fs: 4'd0, a: 64'd0, b: 64'd0, sf: 1'b0, ill: 1'b0};
    rst_n = 1'b0;
    step(); step();
    check("rst_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_fs",    {60'd0, bus.alu_fs}, 64'd0);
    check("rst_a",     bus.alu_a, 64'd0);
    check("rst_b",     bus.alu_b, 64'd0);
    check("rst_sf",    {63'd0, bus.set_flags}, 64'd0);
    check("rst_ill",   {63'd0, bus.illegal}, 64'd0);
    check("rst_flags", {60'd0, bus.flags}, 64'd0);
    rst_n = 1'b1;
    step();

    // T1: single ADD, one-cycle latency
    drive_op(vecs[0]);
    #1 check("t1_in_ready", {63'd0, bus.in_ready}, 64'd1);
    step();
    check("t1_valid", {63'd0, bus.out_valid}, 64'd1);
    check("t1_fs",    {60'd0, bus.alu_fs}, 64'h2);
    check("t1_a",     bus.alu_a, 64'd5);
    check("t1_b",     bus.alu_b, 64'd7);
    check("t1_sf",    {63'd0, bus.set_flags}, 64'd0);
    bus.in_valid = 1'b0;
    step();

    // Table sweep, back-to-back; flag-setting ops latch 4'b1001
    bus.alu_status = 4'b1001;
    foreach (vecs[i]) begin
      drive_op(vecs[i]);
      step();
    end
    bus.in_valid = 1'b0;
    step(); step();
    check("tbl_flags", {60'd0, bus.flags}, 64'h9);

    // T2: SUBIS sets flags; later ADD leaves them
    drive_op(mk(11'b11110001000, 64'd3, 64'd77, 12'd3, 4'b0110, 64'd3, 1'b1, 1'b0));
    bus.alu_status = 4'b0100;
    step();
    check("t2_valid", {63'd0, bus.out_valid}, 64'd1);
    check("t2_fs",    {60'd0, bus.alu_fs}, 64'h6);
    check("t2_b",     bus.alu_b, 64'd3);
    check("t2_sf",    {63'd0, bus.set_flags}, 64'd1);
    bus.in_valid = 1'b0;
    step();
    check("t2_flags", {60'd0, bus.flags}, 64'h4);
    drive_op(vecs[0]);
    bus.alu_status = 4'b1011;
    step();
    bus.in_valid = 1'b0;
    step();
    check("t2_flags_hold", {60'd0, bus.flags}, 64'h4);

    // T4: stall for 3 cycles, then accept with no bubble
    bus.out_ready = 1'b0;
    drive_op(mk(11'b10001011000, 64'd11, 64'd22, 12'h0, 4'b0010, 64'd22, 1'b0, 1'b0));
    step();
    check("t4_valid", {63'd0, bus.out_valid}, 64'd1);
    drive_op(mk(11'b11001011000, 64'd100, 64'd1, 12'h0, 4'b0110, 64'd1, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_in_ready", {63'd0, bus.in_ready}, 64'd0);
      check("t4_hold_v",   {63'd0, bus.out_valid}, 64'd1);
      check("t4_hold_fs",  {60'd0, bus.alu_fs}, 64'h2);
      check("t4_hold_a",   bus.alu_a, 64'd11);
      check("t4_hold_b",   bus.alu_b, 64'd22);
      step();
    end
    bus.out_ready = 1'b1;
    #1 check("t4_in_ready_rel", {63'd0, bus.in_ready}, 64'd1);
    step();
    check("t4_nb_valid", {63'd0, bus.out_valid}, 64'd1);
    check("t4_nb_fs",    {60'd0, bus.alu_fs}, 64'h6);
    check("t4_nb_a",     bus.alu_a, 64'd100);
    bus.in_valid = 1'b0;
    step();

    // T5: flush kills SUBS in stage, blocks input, no flag update
    bus.out_ready = 1'b0;
    bus.alu_status = 4'b1111;
    drive_op(mk(11'b11101011000, 64'd9, 64'd4, 12'h0, 4'b0110, 64'd4, 1'b1, 1'b0));
    step();
    check("t5_valid", {63'd0, bus.out_valid}, 64'd1);
    check("t5_sf",    {63'd0, bus.set_flags}, 64'd1);
    drive_op(mk(11'b10001011000, 64'd1, 64'd2, 12'h0, 4'b0010, 64'd2, 1'b0, 1'b0));
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    #1 check("t5_in_ready", {63'd0, bus.in_ready}, 64'd0);
    step();
    check("t5_flush_valid", {63'd0, bus.out_valid}, 64'd0);
    check("t5_flush_flags", {60'd0, bus.flags}, 64'h4);
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    step();
    check("t5_no_capture", {63'd0, bus.out_valid}, 64'd0);
    check("t5_flags_after", {60'd0, bus.flags}, 64'h4);
    bus.flush = 1'b1;
    step();
    check("t5_idle_flush", {63'd0, bus.out_valid}, 64'd0);
    bus.flush = 1'b0;

    // T6: illegal opcode, then reset mid-stall
    bus.out_ready = 1'b0;
    drive_op(vecs[16]);
    step();
    check("t6_valid", {63'd0, bus.out_valid}, 64'd1);
    check("t6_ill",   {63'd0, bus.illegal}, 64'd1);
    check("t6_fs",    {60'd0, bus.alu_fs}, 64'd0);
    check("t6_sf",    {63'd0, bus.set_flags}, 64'd0);
    check("t6_a",     bus.alu_a, 64'd0);
    check("t6_b",     bus.alu_b, 64'd0);
    bus.in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    check("t6_rst_valid", {63'd0, bus.out_valid}, 64'd0);
    check("t6_rst_ill",   {63'd0, bus.illegal}, 64'd0);
    check("t6_rst_fs",    {60'd0, bus.alu_fs}, 64'd0);
    check("t6_rst_sf",    {63'd0, bus.set_flags}, 64'd0);
    check("t6_rst_a",     bus.alu_a, 64'd0);
    check("t6_rst_b",     bus.alu_b, 64'd0);
    check("t6_rst_flags", {60'd0, bus.flags}, 64'd0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step(); step();

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
